// File: rtl/decode_pipe.sv
// RV32 decode stage: field extraction, immediate generation, register-file read with
// writeback forwarding, load-use interlock and a single registered output bundle.
module decode_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_load,
  input  logic [4:0]      ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_write,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_sub_sra,
  output logic [XLEN-1:0] out_rs1_value,
  output logic [XLEN-1:0] out_rs2_value,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [5:0] NREGS_W   = 6'(NREGS);

  logic [XLEN-1:0] regs [0:NREGS-1];

  logic [6:0]        opc, f7;
  logic [4:0]        rs1_idx, rs2_idx, rd_idx;
  logic [2:0]        f3;
  logic              illegal, rs1_read, rs2_read, rd_write, sub_sra, hazard, accept, wr_en;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_x, rs1_val, rs2_val;

  assign opc     = in_instr[6:0];
  assign rd_idx  = in_instr[11:7];
  assign f3      = in_instr[14:12];
  assign rs1_idx = in_instr[19:15];
  assign rs2_idx = in_instr[24:20];
  assign f7      = in_instr[31:25];

  always_comb begin
    illegal  = 1'b0;
    rs1_read = 1'b1;
    rs2_read = 1'b0;
    sub_sra  = 1'b0;
    imm32    = '0;
    case (opc)
      OP_IMM: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        sub_sra = f7[5] & (f3 == 3'b101);
      end
      OP_LOAD, OP_JALR: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      OP_STORE: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        rs2_read = 1'b1;
      end
      OP_BRANCH: begin
        imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
        rs2_read = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32    = {in_instr[31:12], 12'b0};
        rs1_read = 1'b0;
      end
      OP_JAL: begin
        imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
        rs1_read = 1'b0;
      end
      OP_REG: begin
        rs2_read = 1'b1;
        sub_sra  = f7[5];
      end
      default: illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) begin
      rs1_read = 1'b0;
      rs2_read = 1'b0;
    end
    rd_write = !illegal && (opc != OP_STORE) && (opc != OP_BRANCH) && (rd_idx != 5'd0);
  end

  assign imm_x = XLEN'(imm32);

  assign hazard = ex_load && (ex_rd != 5'd0) &&
                  ((rs1_read && ex_rd == rs1_idx) || (rs2_read && ex_rd == rs2_idx));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign wr_en    = wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREGS_W);

  // Out-of-range indices read as zero; same-cycle writeback wins only when forwarding is built in.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != 5'd0 && {1'b0, idx} < NREGS_W)
      v = (BYPASS != 0 && wb_we && wb_rd == idx) ? wb_data : regs[idx];
    return v;
  endfunction

  assign rs1_val = rf_read(rs1_idx);
  assign rs2_val = rf_read(rs2_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_rd_write  <= 1'b0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_sub_sra   <= 1'b0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
      out_imm       <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_rs1       <= rs1_idx;
      out_rs2       <= rs2_idx;
      out_rd        <= rd_idx;
      out_rd_write  <= rd_write;
      out_opcode    <= opc;
      out_funct3    <= f3;
      out_funct7    <= f7;
      out_sub_sra   <= sub_sra;
      out_rs1_value <= rs1_val;
      out_rs2_value <= rs2_val;
      out_imm       <= imm_x;
      out_illegal   <= illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid && BYPASS != 0 && wr_en) begin
      // A stalled bundle keeps its operands current with later writebacks.
      if (out_rs1 == wb_rd) out_rs1_value <= wb_data;
      if (out_rs2 == wb_rd) out_rs2_value <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: one forwarding instance and one non-forwarding
// instance share the same stimulus so both behaviours are checked side by side.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, wb_we, ex_load, out_ready;
  logic [31:0] in_instr, wb_data;
  logic [4:0]  wb_rd, ex_rd;

  logic        in_ready, out_valid, out_rd_write, out_sub_sra, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [31:0] out_rs1_value, out_rs2_value, out_imm;

  logic        nb_in_ready, nb_out_valid, nb_out_rd_write, nb_out_sub_sra, nb_out_illegal;
  logic [4:0]  nb_out_rs1, nb_out_rs2, nb_out_rd;
  logic [6:0]  nb_out_opcode, nb_out_funct7;
  logic [2:0]  nb_out_funct3;
  logic [31:0] nb_out_rs1_value, nb_out_rs2_value, nb_out_imm;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_load(ex_load),
    .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_write(out_rd_write), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_sub_sra(out_sub_sra),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value), .out_imm(out_imm),
    .out_illegal(out_illegal));

  decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready), .in_instr(in_instr),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_load(ex_load),
    .ex_rd(ex_rd), .out_valid(nb_out_valid), .out_ready(out_ready), .out_rs1(nb_out_rs1),
    .out_rs2(nb_out_rs2), .out_rd(nb_out_rd), .out_rd_write(nb_out_rd_write),
    .out_opcode(nb_out_opcode), .out_funct3(nb_out_funct3), .out_funct7(nb_out_funct7),
    .out_sub_sra(nb_out_sub_sra), .out_rs1_value(nb_out_rs1_value),
    .out_rs2_value(nb_out_rs2_value), .out_imm(nb_out_imm), .out_illegal(nb_out_illegal));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; wb_we = 1'b0;
    wb_rd = '0; wb_data = '0; ex_load = 1'b0; ex_rd = '0; out_ready = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_rs1_value", out_rs1_value, 0);
    check("rst_imm", out_imm, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // write x5 then addi x6,x5,-1
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF28313;
    tick();
    check("addi_valid", out_valid, 1);
    check("addi_rs1_value", out_rs1_value, 32'h1234);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_rd_write", out_rd_write, 1);
    check("addi_rd", out_rd, 6);
    check("addi_opcode", out_opcode, 7'h13);

    // addi x7,x5,0 while x5 <= 0xAA in the same cycle
    in_instr = 32'h00028393; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
    tick();
    check("fwd_valid_b2b", out_valid, 1);
    check("fwd_rd", out_rd, 7);
    check("fwd_rs1_value", out_rs1_value, 32'hAA);
    check("nofwd_rs1_value", nb_out_rs1_value, 32'h1234);

    // load-use on x5
    wb_we = 1'b0; ex_load = 1'b1; ex_rd = 5'd5;
    #1 check("hazard_in_ready", in_ready, 0);
    tick();
    check("hazard_drain_valid", out_valid, 0);
    check("hazard_still_blocked", in_ready, 0);
    // lui x8 does not read rs1, so no stall; write x10 alongside
    in_instr = 32'h00028437; wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h55;
    #1 check("lui_no_hazard", in_ready, 1);
    tick();
    check("lui_valid", out_valid, 1);
    check("lui_rd", out_rd, 8);
    check("lui_imm", out_imm, 32'h00028000);
    ex_load = 1'b0; wb_we = 1'b0; in_instr = 32'h00028393;
    tick();
    check("hazard_release_rd", out_rd, 7);
    check("hazard_release_rs1", out_rs1_value, 32'hAA);

    // add x9,x5,x10 then backpressure with writeback to x10
    in_instr = 32'h00A284B3;
    tick();
    check("add_rs2_value", out_rs2_value, 32'h55);
    check("add_rs2", out_rs2, 10);
    check("add_sub_sra", out_sub_sra, 0);
    out_ready = 1'b0; in_instr = 32'hFFF28313; wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h77;
    #1 check("bp_in_ready", in_ready, 0);
    tick();
    check("bp_refresh_rs2", out_rs2_value, 32'h77);
    check("bp_norefresh_rs2", nb_out_rs2_value, 32'h55);
    wb_we = 1'b0;
    tick();
    tick();
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_rd", out_rd, 9);
    check("bp_hold_rs1", out_rs1_value, 32'hAA);
    check("bp_hold_opcode", out_opcode, 7'h33);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    check("bp_single_transfer", out_valid, 0);

    // sub x11,x5,x10 held, then flushed
    in_valid = 1'b1; in_instr = 32'h40A285B3;
    tick();
    check("sub_sub_sra", out_sub_sra, 1);
    check("sub_rs2_value", out_rs2_value, 32'h77);
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF28313;
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_no_capture", out_valid, 0);

    // illegal word, sw x0,4(x0), srai x12,x5,3
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000;
    tick();
    check("illegal_flag", out_illegal, 1);
    check("illegal_valid", out_valid, 1);
    check("illegal_rd_write", out_rd_write, 0);
    in_instr = 32'h00002223;
    tick();
    check("sw_illegal", out_illegal, 0);
    check("sw_rd_write", out_rd_write, 0);
    check("sw_imm", out_imm, 4);
    in_instr = 32'h4032D613;
    tick();
    check("srai_sub_sra", out_sub_sra, 1);
    check("srai_imm", out_imm, 32'h403);
    check("srai_funct3", out_funct3, 5);

    // reset in the middle of a hold
    in_instr = 32'hFFF28313;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    check("prereset_rs1", out_rs1_value, 32'hAA);
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", out_valid, 0);
    check("async_rst_rs1", out_rs1_value, 0);
    tick();
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_rf_cleared", out_rs1_value, 0);
    check("post_rst_imm", out_imm, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The parameters SHALL be (name, default, meaning), one per line:
- XLEN  32  data width; legal values 32 or 64
- NREGS  32  register-file entries; legal range 2..32
- BYPASS  1  1 = writeback-to-decode forwarding enabled
REQ-002 The ports SHALL be (name, direction, width, meaning), one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  decode can accept
- in_instr  in  32  RV32 instruction word
- flush  in  1  discard the held output and block capture this cycle
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- ex_load  in  1  load currently in EX
- ex_rd  in  5  destination of that load
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_rd_write  out  1  destination write enable
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_sub_sra  out  1  ALU subtract / arithmetic-shift select
- out_rs1_value, out_rs2_value  out  XLEN each  operand values
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  unsupported encoding

Function
REQ-003 Definitions SHALL be: accept = in_valid & in_ready; in_ready = (!out_valid | out_ready) & !hazard & !flush, computed combinationally.
REQ-004 hazard SHALL be: ex_load & ex_rd!=0 & ((rs1_read & ex_rd==instr[19:15]) | (rs2_read & ex_rd==instr[24:20])).
REQ-005 On accept, all out_* SHALL load at the next rising edge and out_valid SHALL go 1; latency is 1 cycle.
REQ-006 While out_valid=1 and out_ready=0, every out_* SHALL hold, except for the operand refresh in REQ-013.
REQ-007 When out_valid & out_ready with no accept in the same cycle, out_valid SHALL go 0 at the next edge; an accept in the same cycle SHALL produce back-to-back output.
REQ-008 flush=1 SHALL clear out_valid at the next edge with priority over hold and capture; data fields are don't-care.
REQ-009 Immediate format by opcode:
- I-type: 0010011, 0000011, 1100111
- S-type: 0100011
- B-type: 1100011 (bit0=0)
- U-type: 0110111, 0010111 (low 12 bits 0)
- J-type: 1101111 (bit0=0)
- 0110011: imm = 0
- Every immediate sign-extended from its top bit to XLEN.
REQ-010 Read and write flags:
- rs1_read = 1 except for 0110111, 0010111 and 1101111.
- rs2_read = 1 only for 0110011, 0100011 and 1100011.
- out_rd_write = 1 except for 0100011 and 1100011, and forced to 0 when rd==0.
REQ-011 out_sub_sra SHALL be funct7[5] for 0110011, funct7[5] & funct3==101 for 0010011, and 0 otherwise.
REQ-012 out_illegal SHALL be 1 when instr[1:0]!=11 or the opcode is outside REQ-009; illegal instructions SHALL also force rd_write, rs1_read and rs2_read to 0, and SHALL still pass downstream.
REQ-013 Register file behaviour:
- NREGS x XLEN storage, written at the edge when wb_we & wb_rd!=0 & wb_rd<NREGS.
- Index 0, and any index >= NREGS, reads 0.
- When BYPASS=1, a capture read with wb_we & wb_rd==rs & rs!=0 SHALL return wb_data.
- When BYPASS=1, a held bundle whose out_rs1/out_rs2 equals a nonzero wb_rd SHALL take wb_data at that edge.
REQ-014 When BYPASS=0, reads SHALL return the pre-write contents; there is no hold refresh.
REQ-015 With XLEN=64, the operand values SHALL be full width and immediates sign-extended to 64 bits.

Reset
REQ-016 rst_n=0 SHALL immediately, independent of clk, clear out_valid and every out_* field to 0, and clear all register-file entries to 0.
REQ-017 Reset asserted mid-hold SHALL drop the bundle; after release, in_ready SHALL equal !hazard & !flush.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- After reset, write x5=0x1234 via wb, then accept addi x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, out_rs1_value=0x1234, out_imm=0xFFFFFFFF, out_rd_write=1.
- Same-edge forwarding: wb_we writes x5=0xAA in the accept cycle, BYPASS=1 -> out_rs1_value=0xAA; with BYPASS=0 -> the previous x5 value.
- Load-use stall: ex_load=1, ex_rd=5, instr reads x5 -> in_ready=0 and out_valid falls after the drain; ex_load=0 -> accept on the next edge.
- Backpressure: out_ready=0 for 3 cycles with wb write to out_rs2 -> fields stable except out_rs2_value updated; out_ready=1 -> single transfer.
- flush asserted while holding a bundle -> out_valid=0 next edge and no capture that cycle.
- Illegal word 0x00000000 and sw x0,4(x0) -> out_illegal=1 for the first; the second gives out_rd_write=0 and out_imm=4.
